mips_cpu: RTL and testbench
===========================

// Module: mips_cpu
// PURPOSE
//   Single-cycle MIPS32-subset processor core of the character-terminal system.
//   Fetches from an external instruction ROM and drives one shared data port.
//   Character text buffer lives in data space from 0x2000 and is scanned by VGA.
//   No caches, no pipeline, no delay slots, no exceptions/interrupts.
// PARAMETERS
//   RESET_PC   32'h0000_0000  pc value loaded on reset
//   XLEN       32             datapath / register width (fixed at 32)
// PORTS
//   clk     in   1   system clock; all state changes on rising edge
//   reset   in   1   reset, synchronous, active-low (0 = reset)
//   pc      out  32  byte address of current instruction (word aligned)
//   inst    in   32  instruction at pc, combinational from ROM, same cycle
//   raddr   out  32  data address (byte address) for lw/sw
//   rdata   in   32  read data at raddr, combinational, same cycle
//   wren    out  1   data write enable, valid for current instruction
//   wdata   out  32  store data (rt value) when wren=1
// BEHAVIOUR
//   - Reset (reset==0 at posedge): pc<=RESET_PC, all 32 GPRs <=0. While reset
//     is low wren=0 and no register/memory write occurs. First fetch at 0.
//   - One instruction per clk: pc, inst, raddr, wren, wdata all combinational
//     in-cycle; GPR write and pc update at the same rising edge.
//   - Memory commits the write at the rising edge where wren=1.
//   - pc_next: pc+4 default; beq/bne taken: pc+4+(sext(imm16)<<2);
//     j/jal: {pc_plus4[31:28], target26, 2'b00}; jr: rs value.
//   - jal writes pc+4 into $31. No branch delay slot.
//   - R-type (op 0): addu subu and or xor nor slt sltu sllv srlv srav,
//     sll srl sra (shamt), jr. add/sub accepted, treated as addu/subu.
//   - I-type: addiu addi slti sltiu (sext imm); andi ori xori (zext imm);
//     lui rt = imm<<16; lw rt = rdata; sw wren=1, wdata=rt.
//   - Load/store address raddr = rs + sext(imm16); low 2 bits passed through
//     unchanged (no alignment trap). raddr = ALU result for non-memory ops.
//   - slt signed, sltu unsigned compare; result 32'd0/32'd1.
//   - Arithmetic wraps modulo 2^32; overflow ignored.
//   - $0 reads 0 always; writes to $0 discarded. Reads see pre-edge values
//     (rs==rt==rd in same instruction reads old value).
//   - Unknown opcode/funct: NOP (no GPR write, wren=0, pc+4).
//   - wren asserted only for sw; wdata undefined (drive rt) otherwise.
//   - Reset deasserted mid-program: restart cleanly from RESET_PC.
// TESTING
//   - Reset: hold reset=0 3 cycles -> pc=0, wren=0; release -> pc 0,4,8 per
//     clk with inst=0 (NOP).
//   - ALU: lui $1,0x1234; ori $1,$1,0x5678; addiu $2,$0,-1; addu $3,$1,$2
//     -> $3=0x12345677; sltu $4,$1,$2 ->1; slt $5,$1,$2 ->0; sra of
//     0x80000000 by 4 -> 0xF8000000.
//   - Memory: addiu $6,$0,0x2000; sw $3,4($6) -> raddr=0x2004, wren=1,
//     wdata=0x12345677 that cycle; lw $7,4($6) with rdata=0xCAFEBABE -> $7.
//   - Control: beq $0,$0,-1 -> pc stays same; bne equal -> pc+4;
//     jal 0x40 from pc=0x10 -> pc=0x100, $31=0x14; jr $31 -> pc=0x14.
//   - $0: addiu $0,$0,5 then addu $8,$0,$0 -> $8=0; unknown op 0x3F -> NOP.
//   - Reset mid-run at pc=0x100 -> next pc=0, GPRs read 0.

Source files
------------

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS32-subset core for the character-terminal system.
// Executes one instruction per clock. Fetch, decode, execute and the data-port
// request all happen combinationally within the cycle. The GPR write and the
// pc update commit together on the rising edge.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low; loads RESET_PC and clears all GPRs
//   pc     byte address of the current instruction
//   inst   instruction at pc (combinational ROM)
//   raddr  data byte address (ALU result; rs + sext(imm) for lw/sw)
//   rdata  read data at raddr (combinational)
//   wren   store enable, asserted only for sw and never during reset
//   wdata  store data (rt value)
module mips_cpu #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] raddr,
    input  logic [XLEN-1:0] rdata,
    output logic            wren,
    output logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] gpr [32];

    logic [5:0]      op, funct;
    logic [4:0]      rs_a, rt_a, rd_a, shamt, wb_a;
    logic [15:0]     imm;
    logic [XLEN-1:0] rs_v, rt_v, sext, zext, pc_plus4, alu, pc_next, wb_val;
    logic            wb_en, is_sw;

    assign op    = inst[31:26];
    assign rs_a  = inst[25:21];
    assign rt_a  = inst[20:16];
    assign rd_a  = inst[15:11];
    assign shamt = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];

    // $0 is forced to read zero here, so it never needs special write handling
    assign rs_v     = (rs_a == 5'd0) ? '0 : gpr[rs_a];
    assign rt_v     = (rt_a == 5'd0) ? '0 : gpr[rt_a];
    assign sext     = {{(XLEN-16){imm[15]}}, imm};
    assign zext     = {{(XLEN-16){1'b0}}, imm};
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        alu     = '0;
        wb_en   = 1'b0;
        wb_a    = rt_a;
        wb_val  = '0;
        pc_next = pc_plus4;
        is_sw   = 1'b0;
        case (op)
            6'h00: begin
                wb_en = 1'b1;
                wb_a  = rd_a;
                case (funct)
                    6'h00:        alu = rt_v << shamt;
                    6'h02:        alu = rt_v >> shamt;
                    6'h03:        alu = $signed(rt_v) >>> shamt;
                    6'h04:        alu = rt_v << rs_v[4:0];
                    6'h06:        alu = rt_v >> rs_v[4:0];
                    6'h07:        alu = $signed(rt_v) >>> rs_v[4:0];
                    6'h20, 6'h21: alu = rs_v + rt_v;
                    6'h22, 6'h23: alu = rs_v - rt_v;
                    6'h24:        alu = rs_v & rt_v;
                    6'h25:        alu = rs_v | rt_v;
                    6'h26:        alu = rs_v ^ rt_v;
                    6'h27:        alu = ~(rs_v | rt_v);
                    6'h2A:        alu = {{(XLEN-1){1'b0}}, $signed(rs_v) < $signed(rt_v)};
                    6'h2B:        alu = {{(XLEN-1){1'b0}}, rs_v < rt_v};
                    6'h08: begin
                        wb_en   = 1'b0;
                        pc_next = rs_v;
                    end
                    default:      wb_en = 1'b0;
                endcase
                wb_val = alu;
            end
            6'h02: pc_next = {pc_plus4[XLEN-1:XLEN-4], inst[25:0], 2'b00};
            6'h03: begin
                pc_next = {pc_plus4[XLEN-1:XLEN-4], inst[25:0], 2'b00};
                wb_en   = 1'b1;
                wb_a    = 5'd31;
                wb_val  = pc_plus4;
            end
            6'h04, 6'h05: begin
                alu = rs_v - rt_v;
                // op[0] distinguishes bne from beq
                if ((alu == '0) != op[0])
                    pc_next = pc_plus4 + {sext[XLEN-3:0], 2'b00};
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                case (op)
                    6'h0A:   alu = {{(XLEN-1){1'b0}}, $signed(rs_v) < $signed(sext)};
                    6'h0B:   alu = {{(XLEN-1){1'b0}}, rs_v < sext};
                    6'h0C:   alu = rs_v & zext;
                    6'h0D:   alu = rs_v | zext;
                    6'h0E:   alu = rs_v ^ zext;
                    6'h0F:   alu = {imm, 16'h0000};
                    default: alu = rs_v + sext;
                endcase
                wb_en  = 1'b1;
                wb_val = alu;
            end
            6'h23: begin
                alu    = rs_v + sext;
                wb_en  = 1'b1;
                wb_val = rdata;
            end
            6'h2B: begin
                alu   = rs_v + sext;
                is_sw = 1'b1;
            end
            default: ;
        endcase
    end

    assign raddr = alu;
    assign wdata = rt_v;
    assign wren  = is_sw & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
            for (int unsigned i = 0; i < 32; i++)
                gpr[i] <= '0;
        end else begin
            pc <= pc_next;
            if (wb_en && wb_a != 5'd0)
                gpr[wb_a] <= wb_val;
        end
    end

endmodule

// File: tb/tb_mips_cpu.sv
// Testbench for mips_cpu: an instruction-level reference interpreter predicts
// each cycle's pc/wren/raddr/wdata. The stimulus pushes predictions into a
// queue, and a separate monitor pops them and compares them against the DUT.
module tb_mips_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc, inst = '0, raddr, rdata = '0, wdata;
    logic        wren;

    mips_cpu #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst),
        .raddr(raddr), .rdata(rdata), .wren(wren), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_pc;
        logic [31:0] pc;
        logic        wren;
        bit          chk_addr;
        logic [31:0] addr;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          total = 0, passed = 0;
    logic [31:0] m_r [32];
    logic [31:0] m_pc = '0;
    bit          pc_known = 1'b0;

    // Architectural interpreter: returns this cycle's expected outputs and
    // advances the architectural state to that after the clock edge.
    function automatic exp_t model(bit rst_n, logic [31:0] ins, logic [31:0] rd_in, string tag);
        exp_t e;
        logic [31:0] a, b, si, zi, nxt, val;
        int dst;
        e.tag = tag; e.chk_pc = pc_known; e.pc = m_pc; e.wren = 1'b0;
        e.chk_addr = 1'b0; e.addr = '0; e.data = '0;
        if (!rst_n) begin
            m_pc = 32'h0;
            for (int i = 0; i < 32; i++) m_r[i] = '0;
            pc_known = 1'b1;
            return e;
        end
        a   = m_r[ins[25:21]];
        b   = m_r[ins[20:16]];
        si  = {{16{ins[15]}}, ins[15:0]};
        zi  = {16'h0, ins[15:0]};
        nxt = m_pc + 32'd4;
        dst = -1;
        val = '0;
        case (ins[31:26])
            6'h00: begin
                dst = int'(ins[15:11]);
                case (ins[5:0])
                    6'h00: val = b << ins[10:6];
                    6'h02: val = b >> ins[10:6];
                    6'h03: val = $signed(b) >>> ins[10:6];
                    6'h04: val = b << a[4:0];
                    6'h06: val = b >> a[4:0];
                    6'h07: val = $signed(b) >>> a[4:0];
                    6'h20, 6'h21: val = a + b;
                    6'h22, 6'h23: val = a - b;
                    6'h24: val = a & b;
                    6'h25: val = a | b;
                    6'h26: val = a ^ b;
                    6'h27: val = ~(a | b);
                    6'h2A: val = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    6'h2B: val = (a < b) ? 32'd1 : 32'd0;
                    6'h08: begin dst = -1; nxt = a; end
                    default: dst = -1;
                endcase
            end
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            6'h03: begin dst = 31; val = nxt; nxt = {nxt[31:28], ins[25:0], 2'b00}; end
            6'h04: if (a == b) nxt = nxt + si * 4;
            6'h05: if (a != b) nxt = nxt + si * 4;
            6'h08, 6'h09: begin dst = int'(ins[20:16]); val = a + si; end
            6'h0A: begin dst = int'(ins[20:16]); val = (int'(a) < int'(si)) ? 32'd1 : 32'd0; end
            6'h0B: begin dst = int'(ins[20:16]); val = (a < si) ? 32'd1 : 32'd0; end
            6'h0C: begin dst = int'(ins[20:16]); val = a & zi; end
            6'h0D: begin dst = int'(ins[20:16]); val = a | zi; end
            6'h0E: begin dst = int'(ins[20:16]); val = a ^ zi; end
            6'h0F: begin dst = int'(ins[20:16]); val = zi * 65536; end
            6'h23: begin
                dst = int'(ins[20:16]); val = rd_in;
                e.chk_addr = 1'b1; e.addr = a + si;
            end
            6'h2B: begin
                e.wren = 1'b1; e.chk_addr = 1'b1; e.addr = a + si; e.data = b;
            end
            default: ;
        endcase
        if (dst > 0) m_r[dst] = val;
        m_pc = nxt;
        return e;
    endfunction

    function automatic logic [31:0] R(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] I(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [4:0] rr();
        int unsigned x = $urandom_range(0, 8);
        return (x == 8) ? 5'd31 : 5'(x);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns  [17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                                  6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08};
        logic [5:0] iops [8]  = '{6'h0F, 6'h09, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
        int unsigned s = $urandom_range(0, 23);
        case (s)
            0, 1, 2, 3:       return I(6'h2B, rr(), rr(), 16'($urandom_range(0, 255) * 4));
            4, 5, 6, 7, 8, 9: return R(rr(), rr(), rr(), 5'($urandom), fns[$urandom_range(0, 15)]);
            10, 11, 12, 13, 14, 15: return I(iops[$urandom_range(0, 7)], rr(), rr(), 16'($urandom));
            16, 17:           return I(6'h23, rr(), rr(), 16'($urandom));
            18:               return I(6'h04, rr(), rr(), 16'($urandom_range(0, 15) - 8));
            19:               return I(6'h05, rr(), rr(), 16'($urandom_range(0, 15) - 8));
            20:               return {6'h02, 26'($urandom)};
            21:               return {6'h03, 26'($urandom)};
            22:               return R(rr(), 5'd0, 5'd0, 5'd0, 6'h08);
            default:          return $urandom;
        endcase
    endfunction

    task automatic step(input bit rst_n, input logic [31:0] ins, input logic [31:0] rd_in, input string tag);
        @(negedge clk);
        reset = rst_n; inst = ins; rdata = rd_in;
        q.push_back(model(rst_n, ins, rd_in, tag));
    endtask

    // Same as step, but the expectation is a hand-derived constant
    task automatic stepk(input bit rst_n, input logic [31:0] ins, input logic [31:0] rd_in,
                         input logic [31:0] kpc, input logic kw, input logic [31:0] ka,
                         input logic [31:0] kd, input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst_n; inst = ins; rdata = rd_in;
        e = model(rst_n, ins, rd_in, tag);
        e.chk_pc = 1'b1; e.pc = kpc; e.wren = kw;
        if (kw) begin e.chk_addr = 1'b1; e.addr = ka; e.data = kd; end
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_pc)   chk({e.tag, ".pc"}, pc, e.pc);
            chk({e.tag, ".wren"}, {31'h0, wren}, {31'h0, e.wren});
            if (e.chk_addr) chk({e.tag, ".raddr"}, raddr, e.addr);
            if (e.wren)     chk({e.tag, ".wdata"}, wdata, e.data);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held, then release with NOPs
        step (0, 32'h0, 32'h0, "rst0");
        stepk(0, 32'h0, 32'h0, 32'h0, 1'b0, '0, '0, "rst1");
        stepk(0, I(6'h2B, 5'd0, 5'd0, 16'd0), 32'h0, 32'h0, 1'b0, '0, '0, "rst2_sw");
        stepk(1, 32'h0, 32'h0, 32'h0, 1'b0, '0, '0, "nop0");
        stepk(1, 32'h0, 32'h0, 32'h4, 1'b0, '0, '0, "nop4");
        stepk(1, 32'h0, 32'h0, 32'h8, 1'b0, '0, '0, "nop8");
        // ALU
        step (1, I(6'h0F, 5'd0, 5'd1, 16'h1234), 32'h0, "lui");
        step (1, I(6'h0D, 5'd1, 5'd1, 16'h5678), 32'h0, "ori");
        step (1, I(6'h09, 5'd0, 5'd2, 16'hFFFF), 32'h0, "addiu");
        step (1, R(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h0, "addu");
        step (1, R(5'd1, 5'd2, 5'd4, 5'd0, 6'h2B), 32'h0, "sltu");
        step (1, R(5'd1, 5'd2, 5'd5, 5'd0, 6'h2A), 32'h0, "slt");
        step (1, I(6'h0F, 5'd0, 5'd9, 16'h8000), 32'h0, "lui9");
        step (1, R(5'd0, 5'd9, 5'd10, 5'd4, 6'h03), 32'h0, "sra");
        step (1, I(6'h09, 5'd0, 5'd6, 16'h2000), 32'h0, "base");
        stepk(1, I(6'h2B, 5'd6, 5'd3, 16'd4),  32'h0, 32'h30, 1'b1, 32'h2004, 32'h12345677, "sw_addu");
        stepk(1, I(6'h2B, 5'd6, 5'd4, 16'd8),  32'h0, 32'h34, 1'b1, 32'h2008, 32'h1, "sw_sltu");
        stepk(1, I(6'h2B, 5'd6, 5'd5, 16'd12), 32'h0, 32'h38, 1'b1, 32'h200C, 32'h0, "sw_slt");
        stepk(1, I(6'h2B, 5'd6, 5'd10, 16'd16), 32'h0, 32'h3C, 1'b1, 32'h2010, 32'hF8000000, "sw_sra");
        step (1, I(6'h23, 5'd6, 5'd7, 16'd4), 32'hCAFEBABE, "lw");
        stepk(1, I(6'h2B, 5'd6, 5'd7, 16'd0), 32'h0, 32'h44, 1'b1, 32'h2000, 32'hCAFEBABE, "sw_lw");
        // control flow from a fresh reset
        stepk(0, 32'h0, 32'h0, 32'h48, 1'b0, '0, '0, "rst_ctl");
        stepk(1, I(6'h04, 5'd0, 5'd0, 16'hFFFF), 32'h0, 32'h0, 1'b0, '0, '0, "beq_self");
        stepk(1, I(6'h05, 5'd0, 5'd0, 16'd5), 32'h0, 32'h0, 1'b0, '0, '0, "bne_eq");
        stepk(1, 32'h0, 32'h0, 32'h4, 1'b0, '0, '0, "after_bne");
        stepk(1, 32'h0, 32'h0, 32'h8, 1'b0, '0, '0, "nop8b");
        stepk(1, 32'h0, 32'h0, 32'hC, 1'b0, '0, '0, "nopCb");
        stepk(1, {6'h03, 26'h40}, 32'h0, 32'h10, 1'b0, '0, '0, "jal");
        stepk(1, I(6'h2B, 5'd0, 5'd31, 16'd0), 32'h0, 32'h100, 1'b1, 32'h0, 32'h14, "sw_ra");
        stepk(1, R(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0, 32'h104, 1'b0, '0, '0, "jr");
        stepk(1, 32'h0, 32'h0, 32'h14, 1'b0, '0, '0, "after_jr");
        // $0 and unknown encodings
        stepk(1, I(6'h09, 5'd0, 5'd0, 16'd5), 32'h0, 32'h18, 1'b0, '0, '0, "wr_r0");
        stepk(1, R(5'd0, 5'd0, 5'd8, 5'd0, 6'h21), 32'h0, 32'h1C, 1'b0, '0, '0, "addu_r0");
        stepk(1, I(6'h2B, 5'd0, 5'd8, 16'd0), 32'h0, 32'h20, 1'b1, 32'h0, 32'h0, "sw_r8");
        stepk(1, 32'hFFFF_FFFF, 32'h0, 32'h24, 1'b0, '0, '0, "bad_op");
        stepk(1, R(5'd1, 5'd1, 5'd8, 5'd0, 6'h3F), 32'h0, 32'h28, 1'b0, '0, '0, "bad_fn");
        stepk(1, I(6'h2B, 5'd0, 5'd8, 16'd0), 32'h0, 32'h2C, 1'b1, 32'h0, 32'h0, "sw_r8b");
        // reset mid-run at 0x100
        stepk(1, I(6'h0D, 5'd0, 5'd1, 16'h0055), 32'h0, 32'h30, 1'b0, '0, '0, "ori55");
        stepk(1, I(6'h2B, 5'd0, 5'd1, 16'd0), 32'h0, 32'h34, 1'b1, 32'h0, 32'h55, "sw_55");
        stepk(1, {6'h02, 26'h40}, 32'h0, 32'h38, 1'b0, '0, '0, "j");
        stepk(0, I(6'h2B, 5'd0, 5'd1, 16'd0), 32'h0, 32'h100, 1'b0, '0, '0, "rst_mid");
        stepk(1, I(6'h2B, 5'd0, 5'd1, 16'd0), 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, "sw_after_rst");
        // randomized program with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) step(0, rand_inst(), $urandom, "rand_rst");
            else                             step(1, rand_inst(), $urandom, "rand");
        end
        @(negedge clk);
        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
